// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: pipeline-register enables,
// bubble/flush controls, data-memory wait FSM with timeout, and perf counters.
module pipeline_ctrl #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             loaduse_i,
    input  logic             branch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    input  logic             clear_i,
    output logic             pc_write_o,
    output logic             IFID_write_o,
    output logic             IFID_flush_o,
    output logic             IDEX_bubble_o,
    output logic             IDEX_write_o,
    output logic             EXMEM_write_o,
    output logic             MEMWB_write_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             err_o,
    output logic [1:0]       state_o
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    state_t             r_state;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;
    logic               r_err;

    logic w_freeze;
    logic w_pc_write;
    logic w_ifid_write;
    logic w_ifid_flush;
    logic w_idex_bubble;
    logic w_pipe_write;

    // Hazard resolution; loaduse outranks branch since the branch re-resolves next cycle.
    always_comb begin
        w_freeze      = 1'b0;
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_pipe_write  = 1'b1;

        case (r_state)
            ST_RUN:      w_freeze = dmem_req_i & ~dmem_ack_i;
            ST_MEM_WAIT: w_freeze = ~dmem_ack_i;
            default:     w_freeze = 1'b1;
        endcase

        if (w_freeze) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_pipe_write = 1'b0;
        end else if (loaduse_i) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
        end else if (branch_taken_i) begin
            w_ifid_flush = 1'b1;
        end
    end

    // Reset forces every control low without waiting for a clock.
    assign pc_write_o    = rst_i & w_pc_write;
    assign IFID_write_o  = rst_i & w_ifid_write;
    assign IFID_flush_o  = rst_i & w_ifid_flush;
    assign IDEX_bubble_o = rst_i & w_idex_bubble;
    assign IDEX_write_o  = rst_i & w_pipe_write;
    assign EXMEM_write_o = rst_i & w_pipe_write;
    assign MEMWB_write_o = rst_i & w_pipe_write;

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
    assign err_o       = r_err;
    assign state_o     = r_state;

    // Memory-wait FSM, sticky timeout error, and saturating perf counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (dmem_req_i && !dmem_ack_i) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= WAIT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_ack_i) begin
                        r_state <= ST_RUN;
                    end else if (r_wait_cnt == WAIT_W'(TIMEOUT)) begin
                        r_state <= ST_ERROR;
                        r_err   <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                ST_ERROR: r_state <= ST_ERROR;
                default:  r_state <= ST_RUN;
            endcase

            if (clear_i) begin
                r_stall_cnt <= '0;
                r_flush_cnt <= '0;
            end else begin
                if (!w_pc_write && (r_stall_cnt != {CNT_W{1'b1}}))
                    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                if (w_ifid_flush && (r_flush_cnt != {CNT_W{1'b1}}))
                    r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares each cycle.
module tb_pipeline_ctrl;

    localparam int unsigned CNT_W   = 3;
    localparam int unsigned TIMEOUT = 4;

    // Control word order: pc, IFID_write, IFID_flush, IDEX_bubble, IDEX, EXMEM, MEMWB
    localparam logic [6:0] NORM = 7'b1100111;
    localparam logic [6:0] LU   = 7'b0001111;
    localparam logic [6:0] BR   = 7'b1110111;
    localparam logic [6:0] FRZ  = 7'b0000000;

    typedef struct packed {
        logic [6:0] ctl;
        logic [1:0] st;
        logic       err;
        logic [2:0] sc;
        logic [2:0] fc;
    } exp_t;

    logic             clk_i;
    logic             rst_i;
    logic             loaduse_i;
    logic             branch_taken_i;
    logic             dmem_req_i;
    logic             dmem_ack_i;
    logic             clear_i;
    logic             pc_write_o;
    logic             IFID_write_o;
    logic             IFID_flush_o;
    logic             IDEX_bubble_o;
    logic             IDEX_write_o;
    logic             EXMEM_write_o;
    logic             MEMWB_write_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic             err_o;
    logic [1:0]       state_o;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    pipeline_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .loaduse_i     (loaduse_i),
        .branch_taken_i(branch_taken_i),
        .dmem_req_i    (dmem_req_i),
        .dmem_ack_i    (dmem_ack_i),
        .clear_i       (clear_i),
        .pc_write_o    (pc_write_o),
        .IFID_write_o  (IFID_write_o),
        .IFID_flush_o  (IFID_flush_o),
        .IDEX_bubble_o (IDEX_bubble_o),
        .IDEX_write_o  (IDEX_write_o),
        .EXMEM_write_o (EXMEM_write_o),
        .MEMWB_write_o (MEMWB_write_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o),
        .err_o         (err_o),
        .state_o       (state_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Drive one cycle of inputs just after the rising edge and queue its expectation.
    task automatic step(input logic lu, input logic br, input logic req, input logic ack,
                        input logic clr, input logic rstn, input logic [6:0] ctl,
                        input logic [1:0] st, input logic err, input logic [2:0] sc,
                        input logic [2:0] fc);
        exp_t e;
        @(posedge clk_i);
        #1;
        loaduse_i      = lu;
        branch_taken_i = br;
        dmem_req_i     = req;
        dmem_ack_i     = ack;
        clear_i        = clr;
        rst_i          = rstn;
        e.ctl = ctl;
        e.st  = st;
        e.err = err;
        e.sc  = sc;
        e.fc  = fc;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        exp_t obs;
        forever begin
            @(negedge clk_i);
            if (q.size() != 0) begin
                e = q.pop_front();
                obs.ctl = {pc_write_o, IFID_write_o, IFID_flush_o, IDEX_bubble_o,
                           IDEX_write_o, EXMEM_write_o, MEMWB_write_o};
                obs.st  = state_o;
                obs.err = err_o;
                obs.sc  = stall_cnt_o;
                obs.fc  = flush_cnt_o;
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL step %0d: got ctl=%b st=%0d err=%b stall=%0d flush=%0d, expected ctl=%b st=%0d err=%b stall=%0d flush=%0d",
                             step_no, obs.ctl, obs.st, obs.err, obs.sc, obs.fc,
                             e.ctl, e.st, e.err, e.sc, e.fc);
                end
                step_no++;
            end
        end
    end

    initial begin : stimulus
        int wait_cyc;
        rst_i          = 1'b0;
        loaduse_i      = 1'b0;
        branch_taken_i = 1'b0;
        dmem_req_i     = 1'b0;
        dmem_ack_i     = 1'b0;
        clear_i        = 1'b0;

        //   lu br rq ak cl rn  ctl   st err sc fc
        step(0, 0, 0, 0, 0, 0, FRZ,  0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, NORM, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, NORM, 0, 0, 0, 0);

        // Load-use stall, and load-use masking a taken branch
        step(1, 0, 0, 0, 0, 1, LU,   0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, NORM, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 1, LU,   0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 1, BR,   0, 0, 2, 0);
        step(0, 0, 0, 0, 0, 1, NORM, 0, 0, 2, 1);
        step(0, 0, 0, 0, 1, 1, NORM, 0, 0, 2, 1);

        // Memory wait released by an ack on the third wait cycle
        step(0, 0, 1, 0, 0, 1, FRZ,  0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 1, FRZ,  1, 0, 1, 0);
        step(0, 0, 1, 0, 0, 1, FRZ,  1, 0, 2, 0);
        step(0, 0, 1, 1, 0, 1, NORM, 1, 0, 3, 0);
        step(0, 0, 0, 0, 0, 1, NORM, 0, 0, 3, 0);

        // Priority of a memory stall, hazards on the ack cycle, same-cycle ack, stray ack
        step(1, 0, 1, 0, 0, 1, FRZ,  0, 0, 3, 0);
        step(0, 1, 1, 0, 0, 1, FRZ,  1, 0, 4, 0);
        step(1, 1, 0, 1, 0, 1, LU,   1, 0, 5, 0);
        step(0, 1, 1, 1, 0, 1, BR,   0, 0, 6, 0);
        step(0, 0, 0, 1, 0, 1, NORM, 0, 0, 6, 1);
        step(1, 0, 0, 0, 1, 1, LU,   0, 0, 6, 1);

        // Timeout into ERROR; ack and clear cannot leave it, reset does
        step(0, 0, 1, 0, 0, 1, FRZ,  0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 1, FRZ,  1, 0, 1, 0);
        step(0, 0, 1, 0, 0, 1, FRZ,  1, 0, 2, 0);
        step(0, 0, 1, 0, 0, 1, FRZ,  1, 0, 3, 0);
        step(0, 0, 1, 0, 0, 1, FRZ,  1, 0, 4, 0);
        step(0, 0, 1, 0, 0, 1, FRZ,  2, 1, 5, 0);
        step(0, 0, 0, 1, 0, 1, FRZ,  2, 1, 6, 0);
        step(0, 0, 0, 0, 1, 1, FRZ,  2, 1, 7, 0);
        step(1, 1, 0, 0, 0, 1, FRZ,  2, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, FRZ,  0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, NORM, 0, 0, 0, 0);

        // Flush counter saturation, then clear beating increment
        for (int i = 0; i < 10; i++)
            step(0, 1, 0, 0, 0, 1, BR, 0, 0, 0, (i < 7) ? 3'(i) : 3'd7);
        step(0, 1, 0, 0, 1, 1, BR,   0, 0, 0, 7);
        step(0, 0, 0, 0, 0, 1, NORM, 0, 0, 0, 0);

        // Stall counter saturation and clear
        for (int i = 0; i < 9; i++)
            step(1, 0, 0, 0, 0, 1, LU, 0, 0, (i < 7) ? 3'(i) : 3'd7, 0);
        step(0, 0, 0, 0, 0, 1, NORM, 0, 0, 7, 0);
        step(0, 0, 0, 0, 1, 1, NORM, 0, 0, 7, 0);
        step(0, 0, 0, 0, 0, 1, NORM, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a memory wait
        step(0, 0, 1, 0, 0, 1, FRZ,  0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 1, FRZ,  1, 0, 1, 0);
        step(0, 0, 1, 0, 0, 0, FRZ,  0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, NORM, 0, 0, 0, 0);

        wait_cyc = 0;
        while (q.size() != 0 && wait_cyc < 10) begin
            @(posedge clk_i);
            wait_cyc++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
